io_bridge_arb: RTL
==================

# io_bridge_arb

Parametrised, registered I/O bridge between `NPORT` Wishbone-classic CPU-side slave ports and one device-side master port. It filters requests to a programmable I/O address window and arbitrates round-robin among ports. It adds optional posted writes and a bus-timeout error response. It sits between the CPU/DMA masters and the I/O device cluster, presenting the whole cluster as a single device; the cost is one extra clock of request latency.

## Interface
- `NPORT`, 2: number of slave ports (1..8).
- `DW`, 32: data width; `DW/8` byte selects.
- `AW`, 32: address width.
- `IO_BASE`, 32'hFD00_0000: window base.
- `IO_MASK`, 32'hFF00_0000: a port's address is in the window when `(adr & IO_MASK) == IO_BASE`.
- `TIMEOUT`, 255: WAIT_ACK cycles before error; 0 disables.
- `POST_WR`, 0: 1 = writes are acked to the slave immediately.

Ports:
- `clk_i` in 1: clock; all logic is on its rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `gate_en_i` in 1: when low, no new grants.
- `s_cyc_i`, `s_stb_i`, `s_we_i` in NPORT: per-port cycle, strobe and write.
- `s_sel_i` in NPORT*DW/8; `s_adr_i` in NPORT*AW; `s_dat_i` in NPORT*DW: port p occupies slice p.
- `s_ack_o`, `s_err_o` out NPORT: per-port ack and error.
- `s_dat_o` out NPORT*DW: read data; only the granted slice is nonzero.
- `m_cyc_o`, `m_stb_o`, `m_we_o` out 1; `m_sel_o` out DW/8; `m_adr_o` out AW; `m_dat_o` out DW: device request.
- `m_ack_i`, `m_stall_i` in 1; `m_dat_i` in DW: device response.
- `wr_err_o` out 1: one-cycle pulse when a posted write times out.
- `gnt_o` out NPORT: one-hot current grant; 0 in IDLE.

## Operation
- Port p requests when `s_cyc_i[p] & s_stb_i[p]` and its address is in the window. Out-of-window requests are ignored and never acked.
- Arbitration happens only in IDLE, with `gate_en_i & ~m_stall_i & ~m_ack_i`.
  - Search starts at `last+1` mod NPORT; `last` resets to NPORT-1, so port 0 wins first.
  - The winner is latched into `gnt_o` and `last`.
- States:
  - **IDLE**: on grant, register `m_*` from the winner's slice; set `m_cyc_o`/`m_stb_o`. Go to PWR if `POST_WR & we`, else WAIT_ACK.
  - **WAIT_ACK**:
    - On `m_ack_i`: clear the master bus, capture `m_dat_i` into the granted `s_dat_o` slice (writes capture too), assert `s_ack_o[g]`, go to RESP.
    - Else on timeout count == TIMEOUT: clear the bus, assert `s_err_o[g]`, set data 0, go to RESP.
    - Else if `~s_cyc_i[g]` (abort): clear the bus, go to IDLE with no ack.
  - **RESP**: hold ack/err and data until `~s_stb_i[g]`; then deassert, zero the data, clear `gnt_o`, go to IDLE. If `s_cyc_i[g]` is still high (RMW), the port re-competes normally.
  - **PWR**:
    - `s_ack_o[g]` is asserted the same cycle the master bus is driven, held until `~s_stb_i[g]`.
    - The master bus clears on `m_ack_i`, or on timeout with a `wr_err_o` pulse.
    - Go to IDLE only when both the slave side and the master side are finished.
    - Slave abort is irrelevant once the write is posted.
- Timeout counter: width clog2(TIMEOUT+1), cleared on every grant, saturates; active in WAIT_ACK and PWR.
- `m_sel_o`, `m_adr_o`, `m_dat_o` and `m_we_o` are 0 whenever `m_cyc_o` is low.

## Timing
- Reset: all outputs 0, state IDLE, `last`=NPORT-1, counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Request latency: stb sampled at edge 0, `m_stb_o` high after edge 0.
- Read: `m_ack_i` sampled at edge n, `s_ack_o` and data valid after edge n. Minimum total is 2 cycles from stb to ack.
- `m_ack_i` and timeout in the same cycle: ack wins.
- Slave stb drop and `m_ack_i` in the same cycle in WAIT_ACK: the ack is taken and RESP lasts one cycle.
- Back-to-back: the earliest next grant is the cycle after RESP exits, because IDLE is one cycle.
- Reset assertion mid-transaction clears everything immediately; no ack is issued.

## Test plan
- Single read port 0, adr 32'hFD00_0010, device acks 3 cycles after stb with 32'hDEAD_BEEF → `s_ack_o[0]` 1 cycle after `m_ack_i`, `s_dat_o[31:0]`=32'hDEAD_BEEF, held until stb drops, then 0.
- Ports 0 and 1 request continuously with in-window reads → grants alternate 0,1,0,1; `gnt_o` is one-hot; neither port starves.
- Port 1 at 32'hFE00_0000 (out of window) → `m_cyc_o` stays 0 and no ack over 50 cycles.
- TIMEOUT=8, device never acks → `s_err_o[g]`=1 at cycle 8 after grant, data 0, bus cleared; POST_WR=1 write gives immediate ack and a `wr_err_o` pulse at cycle 8.
- Slave drops cyc 2 cycles into WAIT_ACK → master bus clears next edge, no ack, IDLE.
- `rst_ni` asserted low in WAIT_ACK → all outputs 0 asynchronously; after release, the first grant goes to port 0.

Source files
------------

// File: rtl/io_bridge_arb_if.sv
// Bus bundle for io_bridge_arb: CPU-side slave ports, device-side master port and status.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface io_bridge_arb_if #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32
);
    logic                    gate_en_i;
    logic [NPORT-1:0]        s_cyc_i;
    logic [NPORT-1:0]        s_stb_i;
    logic [NPORT-1:0]        s_we_i;
    logic [NPORT*DW/8-1:0]   s_sel_i;
    logic [NPORT*AW-1:0]     s_adr_i;
    logic [NPORT*DW-1:0]     s_dat_i;
    logic [NPORT-1:0]        s_ack_o;
    logic [NPORT-1:0]        s_err_o;
    logic [NPORT*DW-1:0]     s_dat_o;
    logic                    m_cyc_o;
    logic                    m_stb_o;
    logic                    m_we_o;
    logic [DW/8-1:0]         m_sel_o;
    logic [AW-1:0]           m_adr_o;
    logic [DW-1:0]           m_dat_o;
    logic                    m_ack_i;
    logic                    m_stall_i;
    logic [DW-1:0]           m_dat_i;
    logic                    wr_err_o;
    logic [NPORT-1:0]        gnt_o;

    modport slave (
        input  gate_en_i, s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
        input  m_ack_i, m_stall_i, m_dat_i,
        output s_ack_o, s_err_o, s_dat_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output wr_err_o, gnt_o
    );

    modport master (
        output gate_en_i, s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
        output m_ack_i, m_stall_i, m_dat_i,
        input  s_ack_o, s_err_o, s_dat_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  wr_err_o, gnt_o
    );
endinterface

// File: rtl/io_bridge_arb.sv
// Registered Wishbone I/O bridge: address-window filter, round-robin arbiter,
// optional posted writes and bus-timeout error response toward one device port.
module io_bridge_arb #(
    parameter int unsigned   NPORT   = 2,
    parameter int unsigned   DW      = 32,
    parameter int unsigned   AW      = 32,
    parameter logic [AW-1:0] IO_BASE = AW'(32'hFD00_0000),
    parameter logic [AW-1:0] IO_MASK = AW'(32'hFF00_0000),
    parameter int unsigned   TIMEOUT = 255,
    parameter bit            POST_WR = 1'b0
) (
    input logic            clk_i,
    input logic            rst_ni,
    io_bridge_arb_if.slave bus
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_RESP, ST_PWR} state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NPORT-1:0]    gnt_q, gnt_d;
    logic [NPORT-1:0]    s_ack_q, s_ack_d;
    logic [NPORT-1:0]    s_err_q, s_err_d;
    logic [NPORT*DW-1:0] s_dat_q, s_dat_d;
    logic                m_cyc_q, m_cyc_d;
    logic                m_we_q, m_we_d;
    logic [SW-1:0]       m_sel_q, m_sel_d;
    logic [AW-1:0]       m_adr_q, m_adr_d;
    logic [DW-1:0]       m_dat_q, m_dat_d;
    logic                wr_err_q, wr_err_d;

    logic [NPORT-1:0]    req;
    logic                win_vld;
    logic [IW-1:0]       win_idx;
    logic [CW-1:0]       cnt_inc;
    logic                timeout;

    // In-window requests per port
    always_comb begin
        req = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            req[p] = bus.s_cyc_i[p] & bus.s_stb_i[p] &
                     ((bus.s_adr_i[p*AW +: AW] & IO_MASK) == IO_BASE);
        end
    end

    // Round-robin search starting just after the last winner
    always_comb begin
        int unsigned idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NPORT; k++) begin
            idx = (32'(last_q) + k) % NPORT;
            if (!win_vld && req[IW'(idx)]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    // Counter value including the current waiting cycle; saturates at TIMEOUT
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    assign timeout = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        logic        bus_clr;
        logic        s_busy;
        logic        m_busy;
        int unsigned g;
        int unsigned w;
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        s_ack_d  = s_ack_q;
        s_err_d  = s_err_q;
        s_dat_d  = s_dat_q;
        m_cyc_d  = m_cyc_q;
        m_we_d   = m_we_q;
        m_sel_d  = m_sel_q;
        m_adr_d  = m_adr_q;
        m_dat_d  = m_dat_q;
        wr_err_d = 1'b0;
        bus_clr  = 1'b0;
        s_busy   = s_ack_q[last_q];
        m_busy   = m_cyc_q;
        g        = 32'(last_q);
        w        = 32'(win_idx);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.gate_en_i && !bus.m_stall_i && !bus.m_ack_i && win_vld) begin
                    last_d         = win_idx;
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    cnt_d          = '0;
                    m_cyc_d        = 1'b1;
                    m_we_d         = bus.s_we_i[win_idx];
                    m_sel_d        = bus.s_sel_i[w*SW +: SW];
                    m_adr_d        = bus.s_adr_i[w*AW +: AW];
                    m_dat_d        = bus.s_dat_i[w*DW +: DW];
                    if (POST_WR && bus.s_we_i[win_idx]) begin
                        s_ack_d[win_idx] = 1'b1;
                        state_d          = ST_PWR;
                    end else begin
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (bus.m_ack_i) begin
                    bus_clr              = 1'b1;
                    s_dat_d[g*DW +: DW]  = bus.m_dat_i;
                    s_ack_d[last_q]      = 1'b1;
                    state_d              = ST_RESP;
                end else if (timeout) begin
                    bus_clr              = 1'b1;
                    s_dat_d[g*DW +: DW]  = '0;
                    s_err_d[last_q]      = 1'b1;
                    state_d              = ST_RESP;
                end else if (!bus.s_cyc_i[last_q]) begin
                    bus_clr = 1'b1;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                if (!bus.s_stb_i[last_q]) begin
                    s_ack_d = '0;
                    s_err_d = '0;
                    s_dat_d = '0;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_PWR: begin
                // Slave and device halves of a posted write retire independently
                if (s_busy && !bus.s_stb_i[last_q]) begin
                    s_ack_d[last_q] = 1'b0;
                    s_busy          = 1'b0;
                end
                if (m_busy) begin
                    if (bus.m_ack_i) begin
                        bus_clr = 1'b1;
                        m_busy  = 1'b0;
                    end else if (timeout) begin
                        bus_clr  = 1'b1;
                        wr_err_d = 1'b1;
                        m_busy   = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                if (!s_busy && !m_busy) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus_clr) begin
            m_cyc_d = 1'b0;
            m_we_d  = 1'b0;
            m_sel_d = '0;
            m_adr_d = '0;
            m_dat_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            last_q   <= IW'(NPORT - 1);
            cnt_q    <= '0;
            gnt_q    <= '0;
            s_ack_q  <= '0;
            s_err_q  <= '0;
            s_dat_q  <= '0;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_sel_q  <= '0;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            s_ack_q  <= s_ack_d;
            s_err_q  <= s_err_d;
            s_dat_q  <= s_dat_d;
            m_cyc_q  <= m_cyc_d;
            m_we_q   <= m_we_d;
            m_sel_q  <= m_sel_d;
            m_adr_q  <= m_adr_d;
            m_dat_q  <= m_dat_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.s_ack_o  = s_ack_q;
    assign bus.s_err_o  = s_err_q;
    assign bus.s_dat_o  = s_dat_q;
    assign bus.m_cyc_o  = m_cyc_q;
    assign bus.m_stb_o  = m_cyc_q;
    assign bus.m_we_o   = m_we_q;
    assign bus.m_sel_o  = m_sel_q;
    assign bus.m_adr_o  = m_adr_q;
    assign bus.m_dat_o  = m_dat_q;
    assign bus.wr_err_o = wr_err_q;
    assign bus.gnt_o    = gnt_q;
endmodule
